// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master peripheral: register map, bit
// positions inside CTRL/STATUS, and the transfer FSM encoding.
package spi_pkg;

  localparam logic [3:0] ADDR_CTRL   = 4'h0;
  localparam logic [3:0] ADDR_TXDATA = 4'h4;
  localparam logic [3:0] ADDR_RXDATA = 4'h8;
  localparam logic [3:0] ADDR_STATUS = 4'hC;

  localparam int CTRL_CS_BIT   = 0;
  localparam int CTRL_IRQ_BIT  = 1;
  localparam int STAT_BUSY_BIT = 0;
  localparam int STAT_DONE_BIT = 1;

  localparam logic [2:0] LAST_BIT = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SHIFT_LO = 2'd1,
    ST_SHIFT_HI = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

endpackage

// File: rtl/spi_master_if.sv
// CPU register-bus connection for the SPI master: one request cycle,
// response (ready + read data) exactly one cycle later.
interface spi_master_if;
    logic        valid;
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;

    modport master (output valid, we, addr, wdata, input rdata, ready);
    modport slave  (input valid, we, addr, wdata, output rdata, ready);
endinterface

// File: rtl/spi_clkgen.sv
// SCLK half-period timer: while enabled, pulses tick once every CLK_DIV clk
// cycles; the count restarts from zero whenever it is disabled.
module spi_clkgen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic en,
    output logic tick
);

    logic [7:0] cnt;

    assign tick = en && (cnt == 8'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (!resetn || !en) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/spi_master.sv
// Register-mapped SPI mode-0 master for the accelerometer link: one byte per
// TXDATA write, MSB first, with CS under direct software control.
module spi_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic         clk,
    input  logic         resetn,
    spi_master_if.slave  bus,
    output logic         SCLK,
    output logic         MOSI,
    input  logic         MISO,
    output logic         CS,
    output logic         irq
);

    state_t      state, state_nxt;
    logic [1:0]  ctrl;
    logic [7:0]  tx_shift;
    logic [7:0]  rx_shift;
    logic [7:0]  rxdata;
    logic [2:0]  bit_cnt;
    logic        busy;
    logic        done;
    logic        clk_en;
    logic        tick;
    logic [31:0] rd_word;
    logic [23:0] unused_wdata;

    logic wr, rd, tx_wr, rx_rd;
    assign wr    = bus.valid && bus.we;
    assign rd    = bus.valid && !bus.we;
    assign tx_wr = wr && (bus.addr == ADDR_TXDATA) && !busy;
    assign rx_rd = rd && (bus.addr == ADDR_RXDATA);

    assign unused_wdata = bus.wdata[31:8];

    assign CS  = ~ctrl[CTRL_CS_BIT];
    assign irq = done && ctrl[CTRL_IRQ_BIT];

    spi_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
        .clk    (clk),
        .resetn (resetn),
        .en     (clk_en),
        .tick   (tick)
    );

    // NOTE: clocked state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    // BUSY set while IDLE is the pending-start marker for the next cycle.
    always_comb begin
        // NOTE: default first so no path leaves state_nxt unassigned (no latch).
        state_nxt = state;
        unique case (state)
            ST_IDLE:     if (busy) state_nxt = ST_SHIFT_LO;
            ST_SHIFT_LO: if (tick) state_nxt = ST_SHIFT_HI;
            ST_SHIFT_HI: if (tick) state_nxt = (bit_cnt == LAST_BIT) ? ST_DONE : ST_SHIFT_LO;
            ST_DONE:     state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        clk_en = (state == ST_SHIFT_LO) || (state == ST_SHIFT_HI);
        SCLK   = (state == ST_SHIFT_HI);
        MOSI   = clk_en ? tx_shift[7] : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ctrl     <= '0;
            tx_shift <= '0;
            rx_shift <= '0;
            rxdata   <= '0;
            bit_cnt  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            if (wr && (bus.addr == ADDR_CTRL)) ctrl <= bus.wdata[1:0];

            if (tx_wr) begin
                tx_shift <= bus.wdata[7:0];
                busy     <= 1'b1;
            end

            if (state == ST_IDLE) bit_cnt <= '0;

            // MISO is captured on the edge where SCLK goes high.
            if (state == ST_SHIFT_LO && tick) rx_shift <= {rx_shift[6:0], MISO};

            if (state == ST_SHIFT_HI && tick) begin
                tx_shift <= {tx_shift[6:0], 1'b0};
                if (bit_cnt != LAST_BIT) bit_cnt <= bit_cnt + 3'd1;
            end

            if (state == ST_DONE) begin
                rxdata <= rx_shift;
                busy   <= 1'b0;
            end

            // Completion has priority over a same-cycle RXDATA read.
            if (state == ST_DONE)    done <= 1'b1;
            else if (tx_wr || rx_rd) done <= 1'b0;
        end
    end

    // TXDATA is write-only and reads back as zero.
    always_comb begin
        rd_word = '0;
        unique case (bus.addr)
            ADDR_CTRL:   rd_word[1:0] = ctrl;
            ADDR_RXDATA: rd_word[7:0] = rxdata;
            ADDR_STATUS: begin
                rd_word[STAT_BUSY_BIT] = busy;
                rd_word[STAT_DONE_BIT] = done;
            end
            default:     rd_word = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            bus.ready <= 1'b0;
            bus.rdata <= '0;
        end else begin
            bus.ready <= bus.valid;
            bus.rdata <= rd ? rd_word : '0;
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: bus reads push expected data into a
// scoreboard queue that a separate monitor drains on every bus.ready.
module tb_spi_master;
    import spi_pkg::*;

    localparam int CLK_DIV = 4;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic sclk, mosi, cs, irq, miso;
    logic miso_drv = 1'b0;
    logic loop_en  = 1'b0;

    assign miso = loop_en ? mosi : miso_drv;

    spi_master_if bus ();

    spi_master #(.CLK_DIV(CLK_DIV)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus),
        .SCLK   (sclk),
        .MOSI   (mosi),
        .MISO   (miso),
        .CS     (cs),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] exp;
        int          cyc;
        bit          chk;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp   = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          rises   = 0;
    int          cs_high = 0;
    logic [15:0] cap     = '0;
    logic        sclk_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // SPI line monitor: counts SCLK rises, records MOSI at each, counts CS-high cycles.
    initial forever begin
        @(negedge clk);
        if (sclk === 1'b1 && sclk_prev === 1'b0) begin
            rises++;
            cap = {cap[14:0], mosi};
        end
        sclk_prev = sclk;
        if (cs === 1'b1) cs_high++;
    end

    // Scoreboard monitor.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (bus.ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_ready", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check({e.name, "_latency"}, 32'(cyc), 32'(e.cyc + 1));
                if (e.chk) check(e.name, bus.rdata, e.exp);
            end
        end else if (sb_q.size() > 0 && cyc > sb_q[0].cyc + 1) begin
            e = sb_q.pop_front();
            check({e.name, "_no_ready"}, 32'd0, 32'd1);
        end
    end

    task automatic idle();
        @(posedge clk);
        #1;
        bus.valid = 1'b0;
        bus.we    = 1'b0;
    endtask

    task automatic push_exp(input string name, input logic [31:0] exp, input bit chk);
        exp_t e;
        e.name = name;
        e.exp  = exp;
        e.cyc  = cyc;
        e.chk  = chk;
        sb_q.push_back(e);
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d, input string name);
        @(posedge clk);
        #1;
        bus.valid = 1'b1;
        bus.we    = 1'b1;
        bus.addr  = a;
        bus.wdata = d;
        push_exp(name, 32'h0, 1'b0);
    endtask

    task automatic bus_read(input logic [3:0] a, input logic [31:0] exp, input string name);
        @(posedge clk);
        #1;
        bus.valid = 1'b1;
        bus.we    = 1'b0;
        bus.addr  = a;
        bus.wdata = '0;
        push_exp(name, exp, 1'b1);
    endtask

    // Idle until the next bus operation will be driven in cycle 'target'.
    task automatic wait_until(input int target);
        while (cyc < target - 1) idle();
    endtask

    initial begin
        int k, r0, c0;
        bit hit;
        bus.valid = 1'b0;
        bus.we    = 1'b0;
        bus.addr  = '0;
        bus.wdata = '0;

        // Reset state
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cs", cs, 1);
        check("rst_sclk", sclk, 0);
        check("rst_mosi", mosi, 0);
        check("rst_irq", irq, 0);
        check("rst_ready", bus.ready, 0);
        resetn = 1'b1;
        bus_read(ADDR_CTRL, 32'h0, "rst_ctrl");
        bus_read(ADDR_STATUS, 32'h0, "rst_status");
        bus_read(ADDR_RXDATA, 32'h0, "rst_rxdata");
        idle();

        // Loopback 0xA5, latency 16*CLK_DIV+2 = 66
        loop_en = 1'b1;
        bus_write(ADDR_CTRL, 32'h1, "a5_wr_ctrl");
        idle();
        check("a5_cs_low", cs, 0);
        r0 = rises;
        bus_write(ADDR_TXDATA, 32'hA5, "a5_wr_tx");
        k = cyc;
        bus_read(ADDR_STATUS, 32'h1, "a5_busy_early");
        wait_until(k + 66);
        bus_read(ADDR_STATUS, 32'h1, "a5_busy_at_65");
        bus_read(ADDR_STATUS, 32'h2, "a5_done_at_66");
        bus_read(ADDR_RXDATA, 32'hA5, "a5_rxdata");
        bus_read(ADDR_STATUS, 32'h0, "a5_done_cleared");
        idle();
        check("a5_sclk_rises", 32'(rises - r0), 32'd8);
        check("a5_mosi_bits", {24'h0, cap[7:0]}, 32'hA5);
        check("idle_sclk", sclk, 0);
        check("idle_mosi", mosi, 0);

        // MISO held high, TX 0x00 -> RX 0xFF; irq masked with IRQ_EN=0
        loop_en  = 1'b0;
        miso_drv = 1'b1;
        bus_write(ADDR_TXDATA, 32'h00, "ff_wr_tx");
        k = cyc;
        wait_until(k + 67);
        bus_read(ADDR_STATUS, 32'h2, "ff_done");
        idle();
        check("ff_irq_masked", irq, 0);
        bus_read(ADDR_RXDATA, 32'hFF, "ff_rxdata");
        bus_read(ADDR_STATUS, 32'h0, "ff_done_cleared");
        idle();

        // Second TXDATA write while busy is dropped
        loop_en  = 1'b1;
        miso_drv = 1'b0;
        r0 = rises;
        bus_write(ADDR_TXDATA, 32'h11, "drop_wr_11");
        k = cyc;
        idle();
        bus_write(ADDR_TXDATA, 32'h22, "drop_wr_22");
        wait_until(k + 67);
        bus_read(ADDR_STATUS, 32'h2, "drop_done");
        bus_read(ADDR_RXDATA, 32'h11, "drop_rxdata");
        idle();
        check("drop_sclk_rises", 32'(rises - r0), 32'd8);
        check("drop_mosi_bits", {24'h0, cap[7:0]}, 32'h11);

        // IRQ enabled: set on completion, cleared the cycle after RXDATA read
        bus_write(ADDR_CTRL, 32'h3, "irq_wr_ctrl");
        bus_write(ADDR_TXDATA, 32'h5A, "irq_wr_tx");
        k = cyc;
        idle();
        check("irq_low_busy", irq, 0);
        wait_until(k + 68);
        check("irq_set", irq, 1);
        bus_read(ADDR_RXDATA, 32'h5A, "irq_rxdata");
        idle();
        check("irq_cleared", irq, 0);

        // Reset at the 4th SCLK rise aborts the transfer
        bus_write(ADDR_CTRL, 32'h1, "abort_wr_ctrl");
        r0 = rises;
        bus_write(ADDR_TXDATA, 32'hC3, "abort_wr_tx");
        idle();
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk);
            #1;
            if (rises - r0 >= 4) hit = 1'b1;
        end
        check("abort_wait_edge4", {31'h0, hit}, 32'd1);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        check("abort_sclk", sclk, 0);
        check("abort_cs", cs, 1);
        check("abort_mosi", mosi, 0);
        check("abort_irq", irq, 0);
        resetn = 1'b1;
        bus_read(ADDR_STATUS, 32'h0, "abort_status");
        bus_read(ADDR_RXDATA, 32'h0, "abort_rxdata");
        bus_read(ADDR_CTRL, 32'h0, "abort_ctrl");
        idle();

        // Back-to-back bytes 0x0B, 0x00 with CS held low
        bus_write(ADDR_CTRL, 32'h1, "b2b_wr_ctrl");
        idle();
        c0 = cs_high;
        r0 = rises;
        bus_write(ADDR_TXDATA, 32'h0B, "b2b_wr_0b");
        k = cyc;
        wait_until(k + 68);
        check("b2b_gap_sclk", sclk, 0);
        check("b2b_gap_cs", cs, 0);
        bus_write(ADDR_TXDATA, 32'h00, "b2b_wr_00");
        k = cyc;
        wait_until(k + 68);
        bus_read(ADDR_RXDATA, 32'h00, "b2b_rxdata");
        idle();
        check("b2b_sclk_rises", 32'(rises - r0), 32'd16);
        check("b2b_mosi_bits", {16'h0, cap}, 32'h0B00);
        check("b2b_cs_high_cycles", 32'(cs_high - c0), 32'd0);

        repeat (5) idle();
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, meaning clk cycles per SCLK half-period (legal 2..255).
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-004 SHALL have ports bus_valid input 1, bus_we input 1, bus_addr input 4, bus_wdata input 32, bus_rdata output 32, bus_ready output 1, forming a CPU register-bus slave.
REQ-005 SHALL have ports SCLK output 1, MOSI output 1, MISO input 1, CS output 1 (active low), forming the SPI link to the accelerometer.
REQ-006 SHALL have port irq  output 1  high while the DONE flag is set and IRQ_EN=1.

Function
REQ-007 Register map (word offsets): 0x0 CTRL {bit0 CS_ASSERT, bit1 IRQ_EN}; 0x4 TXDATA [7:0]; 0x8 RXDATA [7:0]; 0xC STATUS {bit0 BUSY, bit1 DONE}.
REQ-008 bus_ready SHALL pulse exactly one cycle after any bus_valid cycle (one-cycle latency), with bus_rdata valid in that same cycle; unused bits read 0; writes to RXDATA/STATUS are ignored.
REQ-009 CS SHALL equal ~CTRL.CS_ASSERT; the block never drives CS on its own, so multi-byte bursts hold CS low across bytes.
REQ-010 Write to TXDATA while IDLE SHALL latch the byte, set BUSY, clear DONE, and start a transfer next cycle; write while BUSY SHALL be dropped with no effect.
REQ-011 Transfer: SPI mode 0 (CPOL=0, CPHA=0), 8 bits, MSB first; MOSI presents bit 7 from the first cycle of SHIFT_LO.
REQ-012 FSM states IDLE -> SHIFT_LO -> SHIFT_HI -> (SHIFT_LO x7 more) -> DONE -> IDLE.
REQ-013 SHIFT_LO: SCLK=0 for CLK_DIV cycles, then -> SHIFT_HI; SHIFT_HI: SCLK=1 for CLK_DIV cycles; MISO SHALL be sampled on the clk cycle SCLK rises.
REQ-014 On leaving SHIFT_HI, MOSI SHALL advance to the next bit; after bit 0 -> DONE.
REQ-015 DONE lasts one cycle: RXDATA <= assembled byte, BUSY <= 0, DONE <= 1; total latency write-to-BUSY-clear = 16*CLK_DIV + 2 cycles.
REQ-016 DONE flag SHALL clear on a read of RXDATA or a new TXDATA write; if both a RXDATA read and transfer completion occur in the same cycle, completion wins (DONE=1).
REQ-017 Half-period counter width SHALL be 8 bits; bit counter 3 bits, no wrap beyond 8 bits.
REQ-018 SCLK SHALL be 0 and MOSI 0 whenever IDLE.
REQ-019 CTRL changes during a transfer SHALL take effect immediately on CS but SHALL NOT abort the transfer.

Reset
REQ-020 On resetn=0 at a clk edge: FSM IDLE, CTRL=0, RXDATA=0, BUSY=0, DONE=0, SCLK=0, MOSI=0, CS=1, irq=0, bus_ready=0.
REQ-021 Reset mid-transfer SHALL abort immediately with no partial RXDATA update and no DONE.

Structure
REQ-022 Register offsets, STATUS/CTRL bit indices and FSM state encodings SHALL live in shared package spi_pkg.
REQ-023 The SCLK half-period counter SHALL be one sub-module, spi_clkgen, emitting a tick each CLK_DIV cycles while enabled.
REQ-024 Top integrates into system beside existing peripherals at an address window decoded by system.

Verification
REQ-025 Write CTRL=0x1, TXDATA=0xA5 with MISO looped to MOSI -> CS=0, MOSI bits 1,0,1,0,0,1,0,1, RXDATA=0xA5, BUSY clear after 66 cycles (CLK_DIV=4).
REQ-026 MISO held 1, TXDATA=0x00 -> RXDATA=0xFF, DONE=1; RXDATA read -> DONE=0.
REQ-027 Write TXDATA=0x11 then TXDATA=0x22 two cycles later -> only 0x11 shifted out, 8 SCLK rising edges total.
REQ-028 CTRL=0x3, transfer completes -> irq=1; read RXDATA -> irq=0 next cycle.
REQ-029 resetn low at SCLK edge 4 of a transfer -> next cycle SCLK=0, CS=1, BUSY=0, RXDATA unchanged (0).
REQ-030 Two back-to-back bytes 0x0B, 0x00 with CS_ASSERT held -> CS stays 0 across both; SCLK idle 0 between bytes.
